// File: rtl/dpsk_pkg.sv
// rtl/dpsk_pkg.sv - shared DPSK framing types and constants
package dpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] HEAD_FRAME1 = 32'h5555_ffff;
  localparam logic [31:0] HEAD_FRAME2 = 32'h5555_aaaa;

  function automatic int frame_bytes(input int data_len);
    return data_len / 8;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// rtl/sync_byte_fifo.sv - single-clock FIFO with level, same-cycle push and pop
module sync_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign level    = count;
  // Head entry is visible without a pop so the consumer can prefetch.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - buffers UART bytes and paces header/DPSK payload/gap bits to the modulator
module tx_frame_scheduler
  import dpsk_pkg::*;
#(
  parameter int          FRAME_DATA_LEN = 16,
  parameter logic [31:0] HEAD_WORD      = HEAD_FRAME1,
  parameter int          GAP_BITS       = 8,
  parameter int          FIFO_DEPTH     = 64,
  parameter int          TIMEOUT_TICKS  = 1024,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [7:0]                    uart_frame_data,
  input  logic                          uart_frame_data_vld,
  output logic                          frame_uart_ready,
  input  logic                          bit_tick,
  output logic                          frame_mod_data,
  output logic                          frame_mod_data_vld,
  output logic                          frame_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int              LW        = $clog2(FIFO_DEPTH) + 1;
  localparam int              TW        = $clog2(TIMEOUT_TICKS);
  localparam int              FB        = frame_bytes(FRAME_DATA_LEN);
  localparam logic [LW-1:0]   FB_L      = LW'(FB);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [15:0]     HEAD_LAST = 16'd31;
  localparam logic [15:0]     DATA_LAST = 16'(32 + FRAME_DATA_LEN - 1);
  localparam logic [7:0]      GAP_LAST  = 8'(GAP_BITS - 1);

  tx_state_t       state;
  tx_state_t       state_next;
  logic [15:0]     bit_cnt;
  logic [7:0]      gap_cnt;
  logic [TW-1:0]   to_cnt;
  logic [LW-1:0]   send_cnt;
  logic [LW-1:0]   used_cnt;
  logic            prev_bit;
  logic [7:0]      shift_byte;

  logic            push;
  logic            pop_req;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;

  logic            start;
  logic            emit;
  logic            line_bit;
  logic            partial;
  logic [4:0]      head_idx;
  logic [7:0]      cur_byte;

  assign push             = uart_frame_data_vld && !fifo_full;
  assign frame_uart_ready = !fifo_full;
  assign frame_busy       = (state != ST_IDLE);
  assign partial          = (fifo_level != '0) && (fifo_level < FB_L);
  assign head_idx         = 5'd31 - bit_cnt[4:0];

  sync_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .push      (push),
    .push_data (uart_frame_data),
    .pop       (pop_req),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    emit       = 1'b0;
    line_bit   = 1'b0;
    pop_req    = 1'b0;
    cur_byte   = shift_byte;
    case (state)
      ST_IDLE: begin
        if ((fifo_level >= FB_L) || (partial && (to_cnt == TO_LAST))) begin
          start      = 1'b1;
          state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (bit_tick) begin
          emit     = 1'b1;
          line_bit = HEAD_WORD[head_idx];
          if (bit_cnt == HEAD_LAST) state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          emit = 1'b1;
          // Byte boundary: take a latched-count byte from the FIFO, else pad.
          if (bit_cnt[2:0] == 3'd0) begin
            if ((used_cnt < send_cnt) && !fifo_empty) begin
              cur_byte = fifo_dout;
              pop_req  = 1'b1;
            end else begin
              cur_byte = PAD_BYTE;
            end
          end
          line_bit = prev_bit ^ cur_byte[0];
          if (bit_cnt == DATA_LAST) state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          emit = 1'b1;
          if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bit_cnt            <= '0;
      gap_cnt            <= '0;
      to_cnt             <= '0;
      send_cnt           <= '0;
      used_cnt           <= '0;
      prev_bit           <= 1'b0;
      shift_byte         <= '0;
      frame_mod_data     <= 1'b0;
      frame_mod_data_vld <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      if (push || (fifo_level == '0) || (state != ST_IDLE)) to_cnt <= '0;
      else if (bit_tick && partial)                         to_cnt <= to_cnt + TW'(1);

      if (start) begin
        bit_cnt  <= '0;
        used_cnt <= '0;
        send_cnt <= (fifo_level < FB_L) ? fifo_level : FB_L;
        prev_bit <= HEAD_WORD[0];
      end else begin
        if (emit && (state != ST_GAP)) bit_cnt <= bit_cnt + 16'd1;
        if (pop_req) used_cnt <= used_cnt + LW'(1);
        if (emit && (state == ST_DATA)) begin
          prev_bit   <= line_bit;
          shift_byte <= cur_byte >> 1;
        end
      end

      if (state != ST_GAP) gap_cnt <= '0;
      else if (emit)       gap_cnt <= gap_cnt + 8'd1;

      if (emit) frame_mod_data <= line_bit;
      frame_mod_data_vld <= emit;

      if (uart_frame_data_vld && fifo_full) overflow <= 1'b1;
    end
  end

endmodule
